gravsim_datafile: RTL
=====================

Name: gravsim_datafile

Overview:
- Planet-state register bank for GravSim: holds the 113-word single-precision datafile that the physics FSM reads combinationally and writes back through its 3-port write bus.
- Exposes an Avalon-MM slave so the NIOS host can load and read G, planet count and planet vectors.
- Contains the step sequencer that drives FSM_START/FSM_DONE for N back-to-back timesteps.

Parameters:
- NUM_WORDS, 113, datafile depth in 32-bit words.
- AVL_AW, 7, Avalon word-address width.
- MAX_STEPS_W, 8, width of the step-count field.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- AVL_CS  in  1  Avalon chipselect
- AVL_READ  in  1  read strobe
- AVL_WRITE  in  1  write strobe
- AVL_ADDR  in  AVL_AW  word address
- AVL_WRITEDATA  in  32  host write data
- AVL_READDATA  out  32  host read data, registered
- FSM_WE  in  2  FSM write enable: 01 or 11 = write; 00 and 10 = no write
- ADDR1, ADDR2, ADDR3  in  32 each  FSM write addresses
- DATA1, DATA2, DATA3  in  32 each  FSM write data
- DATAFILE  out  32 x NUM_WORDS  full datafile image, driven from registers
- FSM_START  out  1  request one timestep
- FSM_DONE  in  1  timestep complete
- IRQ  out  1  host interrupt (see Optional Feature)

Behaviour:
- Word map:
  - Word 0 = G.
  - Word 1 = planet count.
  - Word 2 = CSR, not stored in the data array.
  - Words 3..112 = planet vectors.
  - Addresses >= NUM_WORDS read 0 and ignore writes.
- Reset (RESET_N low, async):
  - All data words = 0; CSR fields = 0.
  - FSM_START = 0, AVL_READDATA = 0, IRQ = 0; sequencer in IDLE.
- CSR read value:
  - bit0 = BUSY (sequencer not IDLE).
  - bit1 = DONE (sticky).
  - bits[15:8] = steps remaining.
  - Other bits = 0.
- CSR write fields:
  - bit0 = START.
  - bit1 = write 1 to clear DONE.
  - bit2 = ABORT.
  - bits[15:8] = STEPS; 0 is treated as 1.
- Host reads: AVL_READDATA is updated on the cycle after AVL_CS & AVL_READ (1-cycle latency, no waitrequest). It holds its value otherwise.
- Host data writes (word != 2) commit at the clock edge while IDLE. While BUSY they are dropped; the FSM owns the datafile during a run.
- FSM writes:
  - Committed at the clock edge when FSM_WE is 01 or 11, in any sequencer state.
  - Each ADDRn in the range 3..NUM_WORDS-1 writes DATAn. Addresses 0..2 or >= NUM_WORDS are ignored (G, count and CSR are host-only).
  - Duplicate addresses in one cycle: ADDR3 wins over ADDR2, ADDR2 wins over ADDR1.
- Simultaneous host and FSM write to the same word while IDLE: FSM wins.
- DATAFILE reflects a write from the cycle after the write edge.
- Sequencer states:
  - IDLE: FSM_START = 0. A CSR write with START = 1 loads remaining = STEPS (or 1 if STEPS = 0), clears DONE, goes to RUN. START while BUSY is ignored.
  - RUN: FSM_START = 1. When FSM_DONE = 1: decrement remaining, go to ACK.
  - ACK: FSM_START = 0. Wait for FSM_DONE = 0. Then if remaining = 0 or an abort is pending, go to IDLE, set DONE, clear abort; otherwise go to RUN.
- ABORT is accepted in RUN or ACK and sets an abort-pending flag. The current step always finishes; on the next ACK exit, remaining is forced to 0. ABORT while IDLE has no effect.
- The remaining counter never wraps below 0.
- Reset mid-run: immediate return to IDLE with FSM_START = 0 and the datafile cleared.

Optional Feature:
- Macro: GRAVSIM_IRQ_EN.
- Defined: IRQ is a register. It goes to 1 on the cycle DONE becomes set and clears when the host writes CSR bit1 = 1. CSR bit3 = IRQ enable (R/W, reset 0); IRQ = DONE & enable.
- Undefined: IRQ tied to 0; CSR bit3 reads 0 and ignores writes.

Test Plan:
- Reset: write word 5 = 0x3F800000, then pulse RESET_N low -> word 5 reads 0, FSM_START = 0, CSR = 0x0.
- Host R/W while IDLE: write word 23 = 0x40000000 -> read returns 0x40000000 one cycle after the read strobe; DATAFILE[23] = 0x40000000. Write to word 120 -> reads 0.
- FSM triple write: FSM_WE = 01, ADDR1/2/3 = 24/34/44, DATA = 0x1/0x2/0x3 -> words 24/34/44 = 1/2/3. FSM_WE = 10 -> no change. ADDR1 = ADDR3 = 24, DATA1 = 0xA, DATA3 = 0xB -> word 24 = 0xB. ADDR = 0 -> G unchanged.
- Multi-step: CSR write STEPS = 3 with START; FSM model asserts DONE 5 cycles after START and drops it when START falls -> exactly 3 START pulses, CSR bits[15:8] read 2 then 1 then 0, final CSR = 0x2 (DONE set, BUSY clear).
- Abort and busy lockout: STEPS = 10; set ABORT during the 2nd RUN; host writes word 4 while BUSY -> 2 steps complete, then IDLE with DONE = 1, remaining = 0; word 4 unchanged.
- IRQ (GRAVSIM_IRQ_EN defined, bit3 = 1): single step completes -> IRQ = 1 on the cycle DONE sets; CSR write bit1 = 1 -> IRQ = 0 next cycle. Macro undefined -> IRQ stays 0 throughout.

Source files
------------

// File: rtl/gravsim_datafile.sv
// GravSim planet-state datafile: 113-word register bank shared between the
// NIOS host (Avalon-MM slave) and the physics FSM (3-port write bus), plus
// the step sequencer that issues FSM_START / consumes FSM_DONE.
// Optional host interrupt is built when GRAVSIM_IRQ_EN is defined.
module gravsim_datafile #(
  parameter int unsigned NUM_WORDS   = 113,
  parameter int unsigned AVL_AW      = 7,
  parameter int unsigned MAX_STEPS_W = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       AVL_CS,
  input  logic                       AVL_READ,
  input  logic                       AVL_WRITE,
  input  logic [AVL_AW-1:0]          AVL_ADDR,
  input  logic [31:0]                AVL_WRITEDATA,
  output logic [31:0]                AVL_READDATA,
  input  logic [1:0]                 FSM_WE,
  input  logic [31:0]                ADDR1,
  input  logic [31:0]                ADDR2,
  input  logic [31:0]                ADDR3,
  input  logic [31:0]                DATA1,
  input  logic [31:0]                DATA2,
  input  logic [31:0]                DATA3,
  output logic [NUM_WORDS-1:0][31:0] DATAFILE,
  output logic                       FSM_START,
  input  logic                       FSM_DONE,
  output logic                       IRQ
);

  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CSR_WORD  = 2;
  localparam int unsigned FIRST_VEC = 3;
  localparam int unsigned STEPS_LSB = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [NUM_WORDS-1:0][31:0] dataMem;
  logic [NUM_WORDS-1:0][31:0] dataNext;
  logic [1:0]                 state;
  logic [1:0]                 stateNext;
  logic [MAX_STEPS_W-1:0]     remaining;
  logic [MAX_STEPS_W-1:0]     remNext;
  logic [MAX_STEPS_W-1:0]     stepsLoad;
  logic                       doneFlag;
  logic                       doneNext;
  logic                       abortPend;
  logic                       abortNext;
  logic                       hostWr;
  logic                       csrWr;
  logic                       hostDataWr;
  logic                       hostAddrOk;
  logic [31:0]                csrRd;
  logic [31:0]                rdMux;
  logic                       unusedBits;

  // Only the START/CLR/ABORT/IRQEN/STEPS bits of a CSR write are meaningful
  assign unusedBits = ^AVL_WRITEDATA[31:3];

  // FSM write ports only reach planet-vector words; G, count and CSR are host-only
  function automatic logic vecAddrOk(input logic [31:0] a);
    return (a >= 32'(FIRST_VEC)) && (a < 32'(NUM_WORDS));
  endfunction

  assign hostWr     = AVL_CS & AVL_WRITE;
  assign hostAddrOk = 32'(AVL_ADDR) < NUM_WORDS;
  assign csrWr      = hostWr && (AVL_ADDR == AVL_AW'(CSR_WORD));
  assign hostDataWr = hostWr && (state == ST_IDLE) && hostAddrOk &&
                      (AVL_ADDR != AVL_AW'(CSR_WORD));
  assign stepsLoad  = AVL_WRITEDATA[STEPS_LSB +: MAX_STEPS_W];
  assign DATAFILE   = dataMem;

  // Next datafile image: host first, then FSM ports 1..3 so later ports win
  always_comb begin
    dataNext = dataMem;
    if (hostDataWr) begin
      dataNext[IDX_W'(AVL_ADDR)] = AVL_WRITEDATA;
    end
    if (FSM_WE[0]) begin
      if (vecAddrOk(ADDR1)) dataNext[IDX_W'(ADDR1)] = DATA1;
      if (vecAddrOk(ADDR2)) dataNext[IDX_W'(ADDR2)] = DATA2;
      if (vecAddrOk(ADDR3)) dataNext[IDX_W'(ADDR3)] = DATA3;
    end
  end

  // Datafile storage
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dataMem <= '0;
    end else begin
      dataMem <= dataNext;
    end
  end

  // Step sequencer next-state and CSR flag updates
  always_comb begin
    stateNext = state;
    remNext   = remaining;
    doneNext  = doneFlag;
    abortNext = abortPend;
    if (csrWr && AVL_WRITEDATA[1]) begin
      doneNext = 1'b0;
    end
    if (csrWr && AVL_WRITEDATA[2] && (state != ST_IDLE)) begin
      abortNext = 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (csrWr && AVL_WRITEDATA[0]) begin
          remNext   = (stepsLoad == '0) ? MAX_STEPS_W'(1) : stepsLoad;
          doneNext  = 1'b0;
          abortNext = 1'b0;
          stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (FSM_DONE) begin
          remNext   = (remaining == '0) ? '0 : remaining - MAX_STEPS_W'(1);
          stateNext = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!FSM_DONE) begin
          if ((remaining == '0) || abortPend) begin
            remNext   = '0;
            doneNext  = 1'b1;
            abortNext = 1'b0;
            stateNext = ST_IDLE;
          end else begin
            stateNext = ST_RUN;
          end
        end
      end
      default: begin
        remNext   = '0;
        abortNext = 1'b0;
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and the registered FSM_START request
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      remaining <= '0;
      doneFlag  <= 1'b0;
      abortPend <= 1'b0;
      FSM_START <= 1'b0;
    end else begin
      state     <= stateNext;
      remaining <= remNext;
      doneFlag  <= doneNext;
      abortPend <= abortNext;
      FSM_START <= (stateNext == ST_RUN);
    end
  end

`ifdef GRAVSIM_IRQ_EN
  logic irqEn;
  logic irqEnNext;

  assign irqEnNext = csrWr ? AVL_WRITEDATA[3] : irqEn;

  // Interrupt tracks DONE & enable, rising on the same edge DONE sets
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irqEn <= 1'b0;
      IRQ   <= 1'b0;
    end else begin
      irqEn <= irqEnNext;
      IRQ   <= doneNext & irqEnNext;
    end
  end
`else
  assign IRQ = 1'b0;
`endif

  // CSR read image and host read mux
  always_comb begin
    csrRd    = '0;
    csrRd[0] = (state != ST_IDLE);
    csrRd[1] = doneFlag;
`ifdef GRAVSIM_IRQ_EN
    csrRd[3] = irqEn;
`endif
    csrRd[STEPS_LSB +: MAX_STEPS_W] = remaining;
    rdMux = '0;
    if (AVL_ADDR == AVL_AW'(CSR_WORD)) begin
      rdMux = csrRd;
    end else if (hostAddrOk) begin
      rdMux = dataMem[IDX_W'(AVL_ADDR)];
    end
  end

  // Registered host read data, held between reads
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      AVL_READDATA <= '0;
    end else if (AVL_CS && AVL_READ) begin
      AVL_READDATA <= rdMux;
    end
  end

endmodule
